// File: rtl/pcs_rx_symbol_align_if.sv
// Bit-stream input and code-group output bundle of the PCS receive symbol aligner.
interface pcs_rx_symbol_align_if;
   logic       rx_bit;
   logic       rx_bit_valid;
   logic       link_control;
   logic       RSCD;
   logic [4:0] RXn;
   logic [4:0] RXn_1;
   logic [4:0] RXn_2;
   logic [4:0] RXn_3;
   logic       locked;

   modport master (
      output rx_bit, rx_bit_valid, link_control,
      input  RSCD, RXn, RXn_1, RXn_2, RXn_3, locked
   );

   modport slave (
      input  rx_bit, rx_bit_valid, link_control,
      output RSCD, RXn, RXn_1, RXn_2, RXn_3, locked
   );
endinterface

// File: rtl/pcs_rx_symbol_align.sv
// Aligns the decoded serial bit stream onto 5B code-group boundaries and keeps
// a four-deep code-group history for the PCS receive state machine.
module pcs_rx_symbol_align #(
   parameter int unsigned SIL_TIMEOUT = 64,
   parameter logic [4:0]  ALIGN_SYM   = 5'b11000
) (
   input logic                  clk,
   input logic                  pcs_reset_n,
   pcs_rx_symbol_align_if.slave sym_if
);

   localparam int unsigned GW = 5;
   localparam int unsigned CW = 3;
   localparam int unsigned SW = $clog2(SIL_TIMEOUT + 1);

   localparam logic [GW-1:0] SILENCE      = 5'b11111;
   localparam logic          LINK_DISABLE = 1'b0;
   localparam logic [CW-1:0] LAST_BIT     = CW'(4);
   localparam logic [SW-1:0] SIL_MAX      = SW'(SIL_TIMEOUT);
   localparam logic [SW-1:0] SIL_PRE      = SW'(SIL_TIMEOUT - 1);

   typedef enum logic {HUNT, LOCKED} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] win_q, win_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sil_q, sil_d;
   logic          rscd_q, rscd_d;
   logic          locked_q, locked_d;
   logic [GW-1:0] rxn_q, rxn_d;
   logic [GW-1:0] rxn1_q, rxn1_d;
   logic [GW-1:0] rxn2_q, rxn2_d;
   logic [GW-1:0] rxn3_q, rxn3_d;

   logic [GW-1:0] win_shift_c;
   logic          emit_c;
   logic [GW-1:0] grp_c;

   // Next-state, window, counters and code-group emission
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      sil_d       = sil_q;
      rxn_d       = rxn_q;
      rxn1_d      = rxn1_q;
      rxn2_d      = rxn2_q;
      rxn3_d      = rxn3_q;
      rscd_d      = 1'b0;
      emit_c      = 1'b0;
      win_shift_c = {win_q[GW-2:0], sym_if.rx_bit};
      grp_c       = win_shift_c;

      if (sym_if.link_control == LINK_DISABLE) begin
         state_d = HUNT;
         win_d   = '0;
         cnt_d   = '0;
         sil_d   = '0;
      end else if (sym_if.rx_bit_valid) begin
         // A valid bit always wins over a coincident silence timeout
         sil_d = '0;
         win_d = win_shift_c;
         case (state_q)
            HUNT: begin
               if (win_shift_c == ALIGN_SYM) begin
                  state_d = LOCKED;
                  cnt_d   = '0;
                  emit_c  = 1'b1;
               end
            end
            LOCKED: begin
               if (cnt_q == LAST_BIT) begin
                  cnt_d  = '0;
                  emit_c = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         endcase
      end else begin
         if (sil_q != SIL_MAX) begin
            sil_d = sil_q + SW'(1);
         end
         // Timeout fires only on the edge the counter reaches SIL_TIMEOUT
         if (sil_q == SIL_PRE) begin
            state_d = HUNT;
            win_d   = '0;
            cnt_d   = '0;
            grp_c   = SILENCE;
            if (state_q == LOCKED || rxn_q != SILENCE) begin
               emit_c = 1'b1;
            end
         end
      end

      if (emit_c) begin
         rxn3_d = rxn2_q;
         rxn2_d = rxn1_q;
         rxn1_d = rxn_q;
         rxn_d  = grp_c;
         rscd_d = 1'b1;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge pcs_reset_n) begin
      if (!pcs_reset_n) begin
         state_q  <= HUNT;
         win_q    <= '0;
         cnt_q    <= '0;
         sil_q    <= '0;
         rscd_q   <= 1'b0;
         locked_q <= 1'b0;
         rxn_q    <= SILENCE;
         rxn1_q   <= SILENCE;
         rxn2_q   <= SILENCE;
         rxn3_q   <= SILENCE;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         sil_q    <= sil_d;
         rscd_q   <= rscd_d;
         locked_q <= locked_d;
         rxn_q    <= rxn_d;
         rxn1_q   <= rxn1_d;
         rxn2_q   <= rxn2_d;
         rxn3_q   <= rxn3_d;
      end
   end

   assign sym_if.RSCD   = rscd_q;
   assign sym_if.locked = locked_q;
   assign sym_if.RXn    = rxn_q;
   assign sym_if.RXn_1  = rxn1_q;
   assign sym_if.RXn_2  = rxn2_q;
   assign sym_if.RXn_3  = rxn3_q;

endmodule

// File: tb/tb_pcs_rx_symbol_align.sv
// Directed bench for pcs_rx_symbol_align: expected code-groups are queued as bits
// are driven and matched against the groups captured on each RSCD strobe.
module tb_pcs_rx_symbol_align;

   localparam logic [4:0] SILENCE = 5'b11111;
   localparam logic [4:0] SYNC    = 5'b11000;

   logic clk;
   logic pcs_reset_n;

   pcs_rx_symbol_align_if sif ();

   pcs_rx_symbol_align #(
      .SIL_TIMEOUT (64),
      .ALIGN_SYM   (5'b11000)
   ) dut (
      .clk         (clk),
      .pcs_reset_n (pcs_reset_n),
      .sym_if      (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [4:0] exp_q[$];
   logic [4:0] got [0:255];
   int         n_got = 0;
   int         rd    = 0;

   // Capture every emitted code-group away from the active edge
   always @(negedge clk) begin
      if (pcs_reset_n === 1'b1 && sif.RSCD === 1'b1) begin
         if (n_got < 256) got[n_got] <= sif.RXn;
         n_got <= n_got + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish required=finish");
      $fatal(1, "bench timed out");
   end

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Match emitted groups against the queue, count first so extras or misses show
   task automatic drain(input string tag);
      chk_n({tag, "_count"}, n_got - rd, exp_q.size());
      while (rd < n_got && rd < 256 && exp_q.size() > 0) begin
         chk({tag, "_grp"}, got[rd], exp_q.pop_front());
         rd++;
      end
      rd = n_got;
      exp_q.delete();
   endtask

   task automatic send_bit(input logic b);
      sif.rx_bit       = b;
      sif.rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
      sif.rx_bit_valid = 1'b0;
   endtask

   task automatic send_grp(input logic [4:0] g);
      for (int i = 4; i >= 0; i--) send_bit(g[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      pcs_reset_n      = 1'b0;
      sif.rx_bit       = 1'b0;
      sif.rx_bit_valid = 1'b0;
      sif.link_control = 1'b1;
      #12;
      chk("rst_rscd",   {4'b0, sif.RSCD},   5'd0);
      chk("rst_locked", {4'b0, sif.locked}, 5'd0);
      chk("rst_rxn",    sif.RXn,   SILENCE);
      chk("rst_rxn3",   sif.RXn_3, SILENCE);
      #1;
      pcs_reset_n = 1'b1;

      // First SYNC after reset locks on its fifth bit
      exp_q.push_back(SYNC);
      send_grp(SYNC);
      settle();
      drain("sync_lock");
      chk("lock1_locked", {4'b0, sif.locked}, 5'd1);
      chk("lock1_rxn",    sif.RXn,   SYNC);
      chk("lock1_rxn1",   sif.RXn_1, SILENCE);
      chk("lock1_rxn2",   sif.RXn_2, SILENCE);
      chk("lock1_rxn3",   sif.RXn_3, SILENCE);

      // 63 idle clocks then a bit: no silence
      idle(63);
      send_bit(1'b1);
      settle();
      drain("sil63");
      chk("sil63_locked", {4'b0, sif.locked}, 5'd1);

      // 64 idle clocks: SILENCE emitted and lock dropped
      exp_q.push_back(SILENCE);
      idle(64);
      settle();
      drain("sil64");
      chk("sil64_rxn",    sif.RXn,   SILENCE);
      chk("sil64_rxn1",   sif.RXn_1, SYNC);
      chk("sil64_locked", {4'b0, sif.locked}, 5'd0);

      // Already silent: no repeated SILENCE
      idle(200);
      settle();
      drain("sil_repeat");

      // Lock on the 8th bit of 0,1,1,1,1,0,0,0
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      settle();
      drain("hunt7");
      chk("hunt7_locked", {4'b0, sif.locked}, 5'd0);
      exp_q.push_back(SYNC);
      send_bit(1'b0);
      settle();
      drain("hunt8");
      chk("hunt8_locked", {4'b0, sif.locked}, 5'd1);
      exp_q.push_back(5'b10001);
      send_grp(5'b10001);
      exp_q.push_back(5'b00111);
      send_grp(5'b00111);
      settle();
      drain("stream");
      chk("stream_rxn",  sif.RXn,   5'b00111);
      chk("stream_rxn1", sif.RXn_1, 5'b10001);
      chk("stream_rxn2", sif.RXn_2, SYNC);
      chk("stream_rxn3", sif.RXn_3, SILENCE);

      // Valid bit coincident with the timeout edge keeps lock and counts
      send_bit(1'b1); send_bit(1'b0);
      idle(63);
      send_bit(1'b1);
      settle();
      drain("coinc");
      chk("coinc_locked", {4'b0, sif.locked}, 5'd1);
      send_bit(1'b0);
      settle();
      drain("coinc_bit4");
      exp_q.push_back(5'b10101);
      send_bit(1'b1);
      settle();
      drain("coinc_bit5");
      chk("coinc_rxn", sif.RXn, 5'b10101);

      // DISABLE while streaming: unlock, no strobes, history held
      send_bit(1'b1); send_bit(1'b1);
      sif.link_control = 1'b0;
      send_bit(1'b0);
      settle();
      chk("dis_locked", {4'b0, sif.locked}, 5'd0);
      send_grp(SYNC);
      settle();
      drain("dis_stream");
      chk("dis_locked2", {4'b0, sif.locked}, 5'd0);
      chk("dis_rxn",     sif.RXn,   5'b10101);
      chk("dis_rxn1",    sif.RXn_1, 5'b00111);
      sif.link_control = 1'b1;
      exp_q.push_back(SYNC);
      send_grp(SYNC);
      settle();
      drain("reen");
      chk("reen_locked", {4'b0, sif.locked}, 5'd1);
      chk("reen_rxn1",   sif.RXn_1, 5'b10101);

      // Asynchronous reset in mid-symbol
      send_bit(1'b1); send_bit(1'b0);
      #2;
      pcs_reset_n = 1'b0;
      #1;
      chk("arst_locked", {4'b0, sif.locked}, 5'd0);
      chk("arst_rxn",    sif.RXn,   SILENCE);
      chk("arst_rxn1",   sif.RXn_1, SILENCE);
      chk("arst_rxn3",   sif.RXn_3, SILENCE);
      repeat (3) @(posedge clk);
      #3;
      pcs_reset_n = 1'b1;
      settle();
      drain("arst_quiet");
      exp_q.push_back(SYNC);
      send_grp(SYNC);
      settle();
      drain("arst_relock");
      chk("arst_relock_locked", {4'b0, sif.locked}, 5'd1);
      chk("arst_relock_rxn1",   sif.RXn_1, SILENCE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
